ro_freq_meter: RTL and testbench
================================

# ro_freq_meter

Parametrised ring-oscillator frequency meter for the user project area. It succeeds the plain 16:1 oscillator output mux. The block selects one of `N_CH` oscillator outputs, synchronises it into `wb_clk_i`, and counts rising edges over a programmable gate window. It supports single-shot and continuous measurement, with a done/busy handshake and saturating result. A raw combinational mux output is kept for direct pad observation.

## Interface
- `N_CH`, default 16: number of oscillator channels; must be ≥ 2.
- `SEL_W`, default 4: channel select width; must be ≥ clog2(`N_CH`).
- `CNT_W`, default 24: edge-count result width.
- `GATE_W`, default 20: gate-window length width, in clock cycles.

Ports:
- `wb_clk_i`  in  1: sole clock.
- `wb_rst_i`  in  1: reset, synchronous, active-high.
- `ro_in`  in  N_CH: asynchronous oscillator outputs (pre-divided in the oscillator macro).
- `start`  in  1: begin measurement; sampled only in IDLE.
- `stop`  in  1: abort/leave continuous mode; sampled in every state.
- `ch_sel`  in  SEL_W: channel to measure.
- `gate_cycles`  in  GATE_W: gate length G in cycles; 0 is treated as 1.
- `mode`  in  1: 0 = single-shot, 1 = continuous.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse; `count`/`chan_o`/`overflow` update in the same cycle.
- `count`  out  CNT_W: rising edges counted in the last completed window; saturating.
- `chan_o`  out  SEL_W: channel that produced `count`.
- `overflow`  out  1: last window saturated.
- `ro_mux_o`  out  1: combinational `ro_in[ch_sel]` using live `ch_sel`; 0 if `ch_sel` ≥ `N_CH`.

## Operation
- Synchroniser: selected (latched) channel → sync1 → sync2 → sync3 flops.
  - Rising edge = sync2 & ~sync3.
  - Out-of-range latched channel feeds constant 0.
- Exact counting requires input frequency ≤ f_clk/4. Above that, behaviour is undefined but must not hang the block.
- FSM states:
  - IDLE: on `start` & ~`stop`, latch `ch_sel`, `mode`, and G (0→1), then clear the working counter → SETTLE.
  - SETTLE: 3 cycles flushing the synchroniser; edges ignored → GATE.
  - GATE: G cycles; each detected edge increments the working counter, saturating at 2^CNT_W−1 and setting the working overflow flag. At the end → DONE.
  - DONE: 1 cycle.
    - Assert `done`.
    - Load `count`, `chan_o`, `overflow` from the working registers.
    - Clear the working counter.
    - Next state: `mode`=1 → GATE (no settle; edges in this cycle are not counted); else → IDLE.
- `stop` in any non-IDLE state → IDLE next edge. No `done` pulse; `count`, `chan_o`, `overflow` retain their previous values.
  - `stop` in the DONE cycle: the current result is still published, then → IDLE.
- `start` while busy is ignored; latched config is not updated.
- `start` & `stop` together in IDLE: remain IDLE.
- `ch_sel`/`gate_cycles`/`mode` changes while busy do not affect the running measurement; only `ro_mux_o` follows live `ch_sel`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `count`, `chan_o`, `overflow` = 0; sync flops and working registers = 0.
- `start` sampled at edge E0 → `busy`=1 from E0; SETTLE over cycles 1..3; GATE over cycles 4..3+G.
- `done`=1 for the cycle after edge E0+G+4. Single-shot latency is G+4 cycles; `busy` falls at edge E0+G+5.
- Continuous: consecutive `done` pulses are G+1 cycles apart.
- Result registers are registered outputs and change only on `done` or reset.
- `wb_rst_i` mid-measurement: all outputs return to reset values at that edge.
- Edge-to-count latency is 3 cycles through the synchroniser. An edge arriving in the last 2 GATE cycles may fall into the next window (continuous) or be lost (single); tolerance is ±1 count.

## Test plan
- Reset: hold `wb_rst_i` 2 cycles with `ro_in` toggling → all outputs 0, `busy`=0, no `done`.
- Single-shot: `ro_in[3]` period 8 clk, `ch_sel`=3, G=800, `start` 1 cycle → `done` exactly 804 cycles later, `count`=100±1, `chan_o`=3, `overflow`=0, `busy` low next cycle.
- Overflow: instance with CNT_W=8; period 4, G=2000 → `count`=255, `overflow`=1. Rerun with G=400 → `count`=100±1, `overflow`=0.
- Continuous + stop: `mode`=1, period 10, G=100 → `done` every 101 cycles, `count`=10±1 each. Assert `stop` mid-GATE → `busy`=0 next cycle, no further `done`, `count` holds the last value.
- Handshake edges:
  - `start` pulsed during GATE → ignored; latency unchanged.
  - `start`&`stop` together in IDLE → stays IDLE.
  - `ch_sel` changed from 3 to 5 mid-GATE → `chan_o`=3; `ro_mux_o` follows channel 5 immediately.
- Boundaries:
  - G=0 → `done` 5 cycles after `start`.
  - `ch_sel`=15 with `N_CH`=12 → `count`=0 and `ro_mux_o`=0.
  - `wb_rst_i` during SETTLE → immediate return to reset values.

Source files
------------

// File: rtl/ro_freq_meter_if.sv
// Control/result bundle of the ring-oscillator frequency meter.
// master drives the measurement request, slave is the meter itself.
`timescale 1ns/1ps
interface ro_freq_meter_if #(
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 24,
  parameter int GATE_W = 20
);
  logic              start;
  logic              stop;
  logic [SEL_W-1:0]  ch_sel;
  logic [GATE_W-1:0] gate_cycles;
  logic              mode;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic [SEL_W-1:0]  chan_o;
  logic              overflow;

  modport master (
    output start, stop, ch_sel, gate_cycles, mode,
    input  busy, done, count, chan_o, overflow
  );

  modport slave (
    input  start, stop, ch_sel, gate_cycles, mode,
    output busy, done, count, chan_o, overflow
  );
endinterface

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: picks one oscillator, synchronises it and
// counts its rising edges over a gate window, single-shot or continuous.
`timescale 1ns/1ps
module ro_freq_meter #(
  parameter int N_CH   = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 24,
  parameter int GATE_W = 20
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [N_CH-1:0] ro_in,
  ro_freq_meter_if.slave  bus,
  output logic            ro_mux_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_r;
  state_t            state_s;
  logic [SEL_W-1:0]  chan_r;
  logic              mode_r;
  logic [GATE_W-1:0] gate_r;
  logic [GATE_W-1:0] tmr_r;
  logic              sync1_r;
  logic              sync2_r;
  logic              sync3_r;
  logic              sel_ro_s;
  logic              ro_mux_s;
  logic              edge_s;
  logic [CNT_W-1:0]  work_r;
  logic              work_ovf_r;
  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  count_r;
  logic [SEL_W-1:0]  chan_out_r;
  logic              ovf_r;

  // Measured-channel mux; an out-of-range latched channel reads as constant 0.
  always_comb begin
    sel_ro_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(chan_r) == i) sel_ro_s = ro_in[i];
      else                   sel_ro_s = sel_ro_s;
    end
  end

  // Raw pad-observation mux follows the live channel select.
  always_comb begin
    ro_mux_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(bus.ch_sel) == i) ro_mux_s = ro_in[i];
      else                       ro_mux_s = ro_mux_s;
    end
  end

  assign ro_mux_o = ro_mux_s;
  assign edge_s   = sync2_r & ~sync3_r;

  // Three-flop synchroniser; the third flop only serves edge detection.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= sel_ro_s;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Next-state logic; stop wins everywhere except that DONE still publishes.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.stop) state_s = ST_SETTLE;
        else                        state_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (bus.stop)              state_s = ST_IDLE;
        else if (tmr_r == '0)      state_s = ST_GATE;
        else                       state_s = ST_SETTLE;
      end
      ST_GATE: begin
        if (bus.stop)              state_s = ST_IDLE;
        else if (tmr_r == '0)      state_s = ST_DONE;
        else                       state_s = ST_GATE;
      end
      ST_DONE: begin
        if (bus.stop || !mode_r)   state_s = ST_IDLE;
        else                       state_s = ST_GATE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and per-state datapath (config latch, timer, edge counter).
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r    <= ST_IDLE;
      chan_r     <= '0;
      mode_r     <= 1'b0;
      gate_r     <= '0;
      tmr_r      <= '0;
      work_r     <= '0;
      work_ovf_r <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.start && !bus.stop) begin
            chan_r     <= bus.ch_sel;
            mode_r     <= bus.mode;
            gate_r     <= (bus.gate_cycles == '0) ? GATE_W'(1'b1) : bus.gate_cycles;
            tmr_r      <= GATE_W'(2'd2);
            work_r     <= '0;
            work_ovf_r <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (tmr_r == '0) tmr_r <= gate_r - GATE_W'(1'b1);
          else             tmr_r <= tmr_r - GATE_W'(1'b1);
        end
        ST_GATE: begin
          if (tmr_r != '0) tmr_r <= tmr_r - GATE_W'(1'b1);
          if (edge_s) begin
            if (work_r == CNT_MAX) work_ovf_r <= 1'b1;
            else                   work_r     <= work_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          // Continuous mode re-enters GATE directly, so reload the window here.
          tmr_r      <= gate_r - GATE_W'(1'b1);
          work_r     <= '0;
          work_ovf_r <= 1'b0;
        end
        default: tmr_r <= '0;
      endcase
    end
  end

  // Registered handshake and result outputs; busy covers the done cycle too.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      count_r    <= '0;
      chan_out_r <= '0;
      ovf_r      <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE) || (state_r == ST_DONE);
      done_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        count_r    <= work_r;
        chan_out_r <= chan_r;
        ovf_r      <= work_ovf_r;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.count    = count_r;
  assign bus.chan_o   = chan_out_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 16-channel/24-bit instance and a
// 12-channel/8-bit instance share clock, reset and oscillator stimulus.
`timescale 1ns/1ps
module tb_ro_freq_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ro3_v = 1'b0;
  logic        ro5_v = 1'b0;
  int          half3 = 40;
  logic [15:0] ro_vec;
  logic        mux_a;
  logic        mux_b;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // Channel 3 oscillator; toggles land 3 ns before each rising clock edge.
  initial begin
    #2;
    forever begin
      ro3_v = ~ro3_v;
      #(half3);
    end
  end

  assign ro_vec = {10'b0, ro5_v, 1'b0, ro3_v, 3'b0};

  ro_freq_meter_if #(.SEL_W(4), .CNT_W(24), .GATE_W(20)) ifa ();
  ro_freq_meter_if #(.SEL_W(4), .CNT_W(8),  .GATE_W(20)) ifb ();

  ro_freq_meter #(.N_CH(16), .SEL_W(4), .CNT_W(24), .GATE_W(20)) dut_a (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .ro_in    (ro_vec),
    .bus      (ifa.slave),
    .ro_mux_o (mux_a)
  );

  ro_freq_meter #(.N_CH(12), .SEL_W(4), .CNT_W(8), .GATE_W(20)) dut_b (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .ro_in    (ro_vec[11:0]),
    .bus      (ifb.slave),
    .ro_mux_o (mux_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    step();
    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
  endtask

  task automatic pulse_start_b();
    step();
    ifb.start = 1'b1;
    step();
    ifb.start = 1'b0;
  endtask

  task automatic wait_done_a(input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (ifa.done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic wait_done_b(input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      step();
      if (ifb.done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int done_seen;
    done_seen = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      if (ifa.done !== 1'b0 || ifb.done !== 1'b0) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: got %0d done cycles, expected 0", done_seen);
    end
    n_cmp++;
    if ({ifa.busy, ifa.done, ifa.count, ifa.chan_o, ifa.overflow} !== 31'd0) begin
      n_bad++;
      $display("FAIL reset_outputs_a: got busy=%b cnt=%0d ch=%0d ovf=%b, expected all 0",
               ifa.busy, ifa.count, ifa.chan_o, ifa.overflow);
    end
    n_cmp++;
    if ({ifb.busy, ifb.done, ifb.count, ifb.chan_o, ifb.overflow} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs_b: got busy=%b cnt=%0d ch=%0d ovf=%b, expected all 0",
               ifb.busy, ifb.count, ifb.chan_o, ifb.overflow);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int cyc;
    half3 = 40;
    ifa.ch_sel = 4'd3;
    ifa.gate_cycles = 20'd800;
    ifa.mode = 1'b0;
    pulse_start_a();
    wait_done_a(900, cyc);
    n_cmp++;
    if (cyc !== 804) begin
      n_bad++;
      $display("FAIL single_latency: got %0d cycles, expected 804", cyc);
    end
    n_cmp++;
    if (ifa.count < 24'd99 || ifa.count > 24'd101) begin
      n_bad++;
      $display("FAIL single_count: got %0d, expected 100+-1", ifa.count);
    end
    n_cmp++;
    if (ifa.chan_o !== 4'd3 || ifa.overflow !== 1'b0 || ifa.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_meta: got ch=%0d ovf=%b busy=%b, expected ch=3 ovf=0 busy=1",
               ifa.chan_o, ifa.overflow, ifa.busy);
    end
    step();
    n_cmp++;
    if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      n_bad++;
      $display("FAIL single_end: got busy=%b done=%b, expected 0 0", ifa.busy, ifa.done);
    end
  endtask

  task automatic test_continuous_stop();
    int cyc;
    int seen;
    half3 = 50;
    ifa.gate_cycles = 20'd100;
    ifa.mode = 1'b1;
    pulse_start_a();
    for (int r = 0; r < 3; r++) begin
      wait_done_a(200, cyc);
      n_cmp++;
      if (cyc !== ((r == 0) ? 104 : 101)) begin
        n_bad++;
        $display("FAIL cont_spacing[%0d]: got %0d cycles, expected %0d", r, cyc,
                 (r == 0) ? 104 : 101);
      end
      n_cmp++;
      if (ifa.count < 24'd9 || ifa.count > 24'd11) begin
        n_bad++;
        $display("FAIL cont_count[%0d]: got %0d, expected 10+-1", r, ifa.count);
      end
    end
    ifa.mode = 1'b0;
    for (int k = 0; k < 30; k++) step();
    ifa.stop = 1'b1;
    step();
    ifa.stop = 1'b0;
    n_cmp++;
    if (ifa.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_busy: got %b, expected 0", ifa.busy);
    end
    seen = 0;
    for (int k = 0; k < 250; k++) begin
      step();
      if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0 || ifa.count < 24'd9 || ifa.count > 24'd11) begin
      n_bad++;
      $display("FAIL stop_hold: got %0d active cycles count=%0d, expected 0 and 10+-1",
               seen, ifa.count);
    end
  endtask

  task automatic test_handshake();
    int cyc;
    half3 = 40;
    ro5_v = 1'b1;
    ifa.ch_sel = 4'd3;
    ifa.gate_cycles = 20'd400;
    ifa.mode = 1'b0;
    pulse_start_a();
    cyc = -1;
    for (int k = 1; k <= 500; k++) begin
      step();
      if (k == 50) begin
        ifa.start = 1'b1;
        ifa.ch_sel = 4'd5;
        ifa.gate_cycles = 20'd10;
        ifa.mode = 1'b1;
      end else if (k == 51) begin
        ifa.start = 1'b0;
      end else if (k == 52) begin
        n_cmp++;
        if (mux_a !== 1'b1) begin
          n_bad++;
          $display("FAIL mux_live_hi: got %b, expected 1", mux_a);
        end
        ro5_v = 1'b0;
      end else if (k == 53) begin
        n_cmp++;
        if (mux_a !== 1'b0) begin
          n_bad++;
          $display("FAIL mux_live_lo: got %b, expected 0", mux_a);
        end
      end
      if (ifa.done === 1'b1) begin
        cyc = k;
        break;
      end
    end
    n_cmp++;
    if (cyc !== 404) begin
      n_bad++;
      $display("FAIL busy_start_latency: got %0d cycles, expected 404", cyc);
    end
    n_cmp++;
    if (ifa.chan_o !== 4'd3 || ifa.count < 24'd49 || ifa.count > 24'd51) begin
      n_bad++;
      $display("FAIL busy_cfg_ignored: got ch=%0d cnt=%0d, expected ch=3 cnt=50+-1",
               ifa.chan_o, ifa.count);
    end
    step();
    n_cmp++;
    if (ifa.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_mode_ignored: got busy=%b, expected 0", ifa.busy);
    end
    ifa.ch_sel = 4'd3;
    ifa.mode = 1'b0;
    ifa.gate_cycles = 20'd400;
  endtask

  task automatic test_reset_settle();
    pulse_start_a();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({ifa.busy, ifa.done, ifa.count, ifa.chan_o, ifa.overflow} !== 31'd0) begin
      n_bad++;
      $display("FAIL reset_settle: got busy=%b cnt=%0d ch=%0d ovf=%b, expected all 0",
               ifa.busy, ifa.count, ifa.chan_o, ifa.overflow);
    end
    rst = 1'b0;
    step();
    step();
    n_cmp++;
    if (ifa.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_settle_idle: got busy=%b, expected 0", ifa.busy);
    end
  endtask

  task automatic test_start_stop_idle();
    int seen;
    seen = 0;
    ifa.start = 1'b1;
    ifa.stop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (ifa.busy !== 1'b0) seen++;
    end
    ifa.start = 1'b0;
    ifa.stop = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL start_stop_idle: got %0d active cycles, expected 0", seen);
    end
  endtask

  task automatic test_gate_zero();
    int cyc;
    ifa.gate_cycles = 20'd0;
    pulse_start_a();
    wait_done_a(20, cyc);
    n_cmp++;
    if (cyc !== 5) begin
      n_bad++;
      $display("FAIL gate_zero_latency: got %0d cycles, expected 5", cyc);
    end
    step();
    n_cmp++;
    if (ifa.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL gate_zero_busy: got %b, expected 0", ifa.busy);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    half3 = 20;
    ifb.ch_sel = 4'd3;
    ifb.mode = 1'b0;
    ifb.gate_cycles = 20'd2000;
    pulse_start_b();
    wait_done_b(2100, cyc);
    n_cmp++;
    if (cyc !== 2004 || ifb.count !== 8'd255 || ifb.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_sat: got cyc=%0d cnt=%0d ovf=%b, expected 2004 255 1",
               cyc, ifb.count, ifb.overflow);
    end
    ifb.gate_cycles = 20'd400;
    pulse_start_b();
    wait_done_b(500, cyc);
    n_cmp++;
    if (cyc !== 404 || ifb.count < 8'd99 || ifb.count > 8'd101 || ifb.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_clear: got cyc=%0d cnt=%0d ovf=%b, expected 404 100+-1 0",
               cyc, ifb.count, ifb.overflow);
    end
  endtask

  task automatic test_out_of_range();
    int cyc;
    int bad_mux;
    bad_mux = 0;
    ifb.ch_sel = 4'd3;
    for (int k = 0; k < 8; k++) begin
      step();
      if (mux_b !== ro3_v) bad_mux++;
    end
    ifb.ch_sel = 4'd15;
    for (int k = 0; k < 8; k++) begin
      step();
      if (mux_b !== 1'b0) bad_mux++;
    end
    n_cmp++;
    if (bad_mux !== 0) begin
      n_bad++;
      $display("FAIL mux_range: got %0d wrong samples, expected 0", bad_mux);
    end
    ifb.gate_cycles = 20'd20;
    pulse_start_b();
    wait_done_b(40, cyc);
    n_cmp++;
    if (cyc !== 24 || ifb.count !== 8'd0 || ifb.chan_o !== 4'd15 || ifb.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_result: got cyc=%0d cnt=%0d ch=%0d ovf=%b, expected 24 0 15 0",
               cyc, ifb.count, ifb.chan_o, ifb.overflow);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.start = 1'b0; ifa.stop = 1'b0; ifa.ch_sel = 4'd0; ifa.gate_cycles = 20'd0; ifa.mode = 1'b0;
    ifb.start = 1'b0; ifb.stop = 1'b0; ifb.ch_sel = 4'd0; ifb.gate_cycles = 20'd0; ifb.mode = 1'b0;
    test_reset();
    test_single();
    test_continuous_stop();
    test_handshake();
    test_reset_settle();
    test_start_stop_idle();
    test_gate_zero();
    test_overflow();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
